// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/strobe divider with shadowed, glitch-free reconfiguration.
// Each channel switches to newly written settings only at a period boundary or while it is idle.

module clock_divider_multi_ch #(
   parameter int WIDTH   = 16,
   parameter int DEF_DIV = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             mode_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic             pend_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] sdiv_q, sdiv_d;
   logic             mode_q, mode_d;
   logic             smode_q, smode_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             tc, xfer;

   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      mode_d  = mode_q;
      sdiv_d  = sdiv_q;
      smode_d = smode_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      tc      = en_i && (cnt_q == div_q);
      xfer    = pend_q && (tc || !en_i);

      if (en_i) begin
         if (tc) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = mode_q ? 1'b1 : ~clk_q;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
            clk_d = mode_q ? 1'b0 : clk_q;
         end
      end else begin
         clk_d = mode_q ? 1'b0 : clk_q;
      end

      // The TC action above already used the old mode; new settings govern from next cycle.
      if (xfer) begin
         cnt_d  = '0;
         div_d  = sdiv_q;
         mode_d = smode_q;
         pend_d = 1'b0;
         if (!en_i && smode_q) clk_d = 1'b0;
      end

      // A write coinciding with a transfer lands in the shadow and stays pending.
      if (wr_i) begin
         sdiv_d  = div_i;
         smode_d = mode_i;
         pend_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         div_q   <= WIDTH'(DEF_DIV);
         mode_q  <= 1'b0;
         sdiv_q  <= '0;
         smode_q <= 1'b0;
         pend_q  <= 1'b0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         mode_q  <= mode_d;
         sdiv_q  <= sdiv_d;
         smode_q <= smode_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;
   assign pend_o = pend_q;

endmodule

module clock_divider_multi #(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 16,
   parameter  int DEF_DIV  = 0,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CHANNELS-1:0] en_i,
   input  logic                cfg_we_i,
   input  logic [CH_W-1:0]     cfg_ch_i,
   input  logic [WIDTH-1:0]    cfg_div_i,
   input  logic                cfg_mode_i,
   output logic [CHANNELS-1:0] clk_out_o,
   output logic [CHANNELS-1:0] tick_o,
   output logic [CHANNELS-1:0] cfg_pending_o
);

   // Addresses at or beyond CHANNELS match no instance and are dropped.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic wr;
      assign wr = cfg_we_i && (cfg_ch_i == CH_W'(g));

      clock_divider_multi_ch #(
         .WIDTH  (WIDTH),
         .DEF_DIV(DEF_DIV)
      ) u_ch (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .en_i  (en_i[g]),
         .wr_i  (wr),
         .div_i (cfg_div_i),
         .mode_i(cfg_mode_i),
         .clk_o (clk_out_o[g]),
         .tick_o(tick_o[g]),
         .pend_o(cfg_pending_o[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a countdown-based behavioural model.

module tb_clock_divider_multi;

   localparam int CH  = 5;
   localparam int W   = 16;
   localparam int DEF = 0;
   localparam int CHW = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [CH-1:0]  en = '0;
   logic           cfg_we = 1'b0;
   logic [CHW-1:0] cfg_ch = '0;
   logic [W-1:0]   cfg_div = '0;
   logic           cfg_mode = 1'b0;
   logic [CH-1:0]  clk_out, tick, pend;

   clock_divider_multi #(.CHANNELS(CH), .WIDTH(W), .DEF_DIV(DEF)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .cfg_we_i     (cfg_we),
      .cfg_ch_i     (cfg_ch),
      .cfg_div_i    (cfg_div),
      .cfg_mode_i   (cfg_mode),
      .clk_out_o    (clk_out),
      .tick_o       (tick),
      .cfg_pending_o(pend)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each channel tracks cycles left until its next terminal count.
   int m_left[CH], m_div[CH], m_mode[CH], m_sdiv[CH], m_smode[CH];
   bit m_pend[CH], m_clk[CH], m_tick[CH];
   bit m_valid = 1'b0;

   always @(posedge clk) begin : model
      bit tc, xfer;
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_left[c] = DEF; m_div[c] = DEF; m_mode[c] = 0;
            m_sdiv[c] = 0; m_smode[c] = 0;
            m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
         end else begin
            tc   = en[c] && (m_left[c] == 0);
            xfer = m_pend[c] && (tc || !en[c]);
            m_tick[c] = tc;
            if (en[c]) begin
               if (tc) begin
                  m_left[c] = m_div[c];
                  m_clk[c]  = (m_mode[c] == 1) ? 1'b1 : !m_clk[c];
               end else begin
                  m_left[c] = m_left[c] - 1;
                  if (m_mode[c] == 1) m_clk[c] = 0;
               end
            end else if (m_mode[c] == 1) begin
               m_clk[c] = 0;
            end
            if (xfer) begin
               m_div[c]  = m_sdiv[c];
               m_mode[c] = m_smode[c];
               m_left[c] = m_div[c];
               m_pend[c] = 0;
               if (!en[c] && m_smode[c] == 1) m_clk[c] = 0;
            end
            if (cfg_we && int'(cfg_ch) == c) begin
               m_sdiv[c]  = int'(cfg_div);
               m_smode[c] = int'(cfg_mode);
               m_pend[c]  = 1;
            end
         end
      end
      if (rst) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      logic [CH-1:0] e_clk, e_tick, e_pend;
      if (m_valid) begin
         for (int c = 0; c < CH; c++) begin
            e_clk[c]  = m_clk[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
         end
         check("model_clk_out", 32'(clk_out), 32'(e_clk));
         check("model_tick", 32'(tick), 32'(e_tick));
         check("model_pending", 32'(pend), 32'(e_pend));
      end
   end

   task automatic wr(input int ch, input int div, input bit mode);
      cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_div = W'(div); cfg_mode = mode;
   endtask

   task automatic find_tick(input int ch, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tick[ch]) begin found = 1'b1; break; end
      end
      check(name, 32'(found), 32'd1);
   endtask

   initial begin
      logic [3:0]  v4c, v4t;
      logic [15:0] v16c, v16t;
      logic [19:0] v20c, v20p;
      logic [27:0] v28;
      logic [11:0] v12;
      int b;

      // reset state
      @(negedge clk);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_pending", 32'(pend), 32'd0);
      @(negedge clk);
      rst = 1'b0; en = 5'b00001;

      // ch0 at default div 0: clk/2 toggle, tick always high
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         v4c = {v4c[2:0], clk_out[0]};
         v4t = {v4t[2:0], tick[0]};
      end
      check("s1_clk0", 32'(v4c), 32'b1010);
      check("s1_tick0", 32'(v4t), 32'b1111);
      check("s1_others", 32'(clk_out[4:1] | tick[4:1]), 32'd0);

      // ch1 div 3 mode0 configured while disabled
      wr(1, 3, 1'b0);
      @(negedge clk); cfg_we = 1'b0;
      check("s2_pend_set", 32'(pend[1]), 32'd1);
      @(negedge clk);
      check("s2_pend_clr", 32'(pend[1]), 32'd0);
      en[1] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         v16c = {v16c[14:0], clk_out[1]};
         v16t = {v16t[14:0], tick[1]};
      end
      check("s2_clk1", 32'(v16c), 32'b0001_1110_0001_1110);
      check("s2_tick1", 32'(v16t), 32'b0001_0001_0001_0001);

      // ch2 div 4 pulse mode, rewritten to div 1 mid-period
      wr(2, 4, 1'b1);
      @(negedge clk); cfg_we = 1'b0;
      @(negedge clk); en[2] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         v20c = {v20c[18:0], clk_out[2]};
         v20p = {v20p[18:0], pend[2]};
         if (k == 7) wr(2, 1, 1'b1);
         if (k == 8) cfg_we = 1'b0;
      end
      check("s3_pulses2", 32'(v20c), 32'b00001_00001_01010_10101);
      check("s3_pend2", 32'(v20p), 32'b00000_00110_00000_00000);

      // write at ch1 TC, then two writes before the next TC
      find_tick(1, "s4_find_tick");
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         v28 = {v28[26:0], tick[1]};
         if (k == 3) wr(1, 5, 1'b0);
         if (k == 15) wr(1, 9, 1'b0);
         if (k == 16) wr(1, 2, 1'b0);
         if (k == 4 || k == 17) cfg_we = 1'b0;
      end
      check("s4_ticks1", 32'(v28), 32'b0001_0001_0000_0100_0001_0010_0100);

      // out-of-range channel address is ignored
      wr(5, 1, 1'b1);
      @(negedge clk); cfg_we = 1'b0;
      @(negedge clk);
      check("s5_bad_ch_pend", 32'(pend), 32'd0);

      // disable ch1 mid-period, resume finishes the remaining count
      find_tick(1, "s5_find_tick");
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         v12 = {v12[10:0], tick[1]};
         if (k == 1) en[1] = 1'b0;
         if (k == 6) en[1] = 1'b1;
      end
      check("s5_resume_ticks1", 32'(v12), 32'b0000_0001_0010);

      // reset with a pending write discards everything
      wr(1, 7, 1'b0);
      @(negedge clk); cfg_we = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("s6_rst_clk_out", 32'(clk_out), 32'd0);
      check("s6_rst_tick", 32'(tick), 32'd0);
      check("s6_rst_pend", 32'(pend), 32'd0);
      rst = 1'b0; en = '1;
      @(negedge clk);
      check("s6_all_tick", 32'(tick), 32'b11111);
      check("s6_all_clk_hi", 32'(clk_out), 32'b11111);
      @(negedge clk);
      check("s6_all_clk_lo", 32'(clk_out), 32'd0);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) begin
            b = $urandom_range(0, CH - 1);
            en[b] = ~en[b];
         end
         cfg_we   = ($urandom_range(0, 5) == 0);
         cfg_ch   = CHW'($urandom_range(0, 7));
         cfg_div  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
         cfg_mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cfg_we = 1'b0; rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
